// File: rtl/sar_seq_pkg.sv
// sar_seq_pkg: shared FSM type and default sizing for the SAR conversion sequencer
package sar_seq_pkg;
    localparam int DATA_W = 10;
    localparam int ACC_W = DATA_W + 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT = 63;
    typedef enum logic [1:0] {IDLE, REQ, CONV, GAP} state_t;
endpackage

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: shift-register result FIFO with registered head, push+pop on full, drop report
module sar_result_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    input  logic              ready,
    output logic              drop
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] q [DEPTH];
    logic [DATA_W-1:0] qn [DEPTH];
    logic [AW:0] cnt, cnt_n, wi;
    logic pop, wr, full;
    assign full = cnt == (AW+1)'(DEPTH);
    assign pop = valid && ready;
    assign wr = push && (!full || pop);
    assign drop = push && full && !pop;
    assign dout = q[0];
    always_comb begin
        qn = q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) qn[i] = q[i+1];
            qn[DEPTH-1] = '0;
        end
        wi = cnt - (AW+1)'(pop);
        if (wr) qn[wi[AW-1:0]] = din;
        cnt_n = cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            cnt <= cnt_n;
            valid <= cnt_n != '0;
            q <= qn;
        end
    end
endmodule

// File: rtl/sar_conv_sequencer.sv
// sar_conv_sequencer: issues SAR conversions, averages 2^N codes, queues results, flags timeout/overflow
module sar_conv_sequencer #(
    parameter int DATA_W = sar_seq_pkg::DATA_W,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT = sar_seq_pkg::TIMEOUT,
    parameter int FIFO_DEPTH = sar_seq_pkg::FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic [1:0]          avg_log2,
    output logic                cnvst,
    input  logic                eoc,
    input  logic [DATA_W-1:0]   sar_in,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy,
    output logic                timeout_err,
    output logic                overflow,
    input  logic                err_clr
);
    import sar_seq_pkg::*;
    localparam int SUM_W = DATA_W + 3;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t state, state_n;
    logic [1:0] len;
    logic [3:0] cnt;
    logic [SUM_W-1:0] acc, acc_sum;
    logic [PERIOD_W-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [DATA_W-1:0] res;
    logic cont, push, drop, last, tmo, due;
    assign acc_sum = acc + SUM_W'(sar_in);
    assign last = (cnt + 4'd1) == (4'd1 << len);
    assign tmo = tcnt == TW'(TIMEOUT);
    assign due = pcnt <= PERIOD_W'(1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = (start || en) ? REQ : IDLE;
            REQ: state_n = CONV;
            CONV: state_n = eoc ? ((!en && (cont || last)) ? IDLE : due ? REQ : GAP) : tmo ? IDLE : CONV;
            GAP: state_n = (cont && !en) ? IDLE : due ? REQ : GAP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnvst <= 1'b0;
            busy <= 1'b0;
            len <= '0;
            cnt <= '0;
            acc <= '0;
            pcnt <= '0;
            tcnt <= '0;
            cont <= 1'b0;
            push <= 1'b0;
            res <= '0;
            timeout_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            cnvst <= state_n == REQ;
            busy <= state_n != IDLE;
            push <= 1'b0;
            pcnt <= pcnt - PERIOD_W'(pcnt != '0);
            timeout_err <= (state == CONV && !eoc && tmo) || (timeout_err && !err_clr);
            overflow <= drop || (overflow && !err_clr);
            case (state)
                IDLE: if (start || en) begin
                    len <= avg_log2;
                    acc <= '0;
                    cnt <= '0;
                    cont <= en;
                end
                REQ: begin
                    pcnt <= (period == '0) ? '0 : period - PERIOD_W'(1);
                    tcnt <= TW'(1);
                end
                CONV: if (eoc) begin
                    acc <= acc_sum;
                    cnt <= cnt + 4'd1;
                    if (last) begin
                        push <= 1'b1;
                        res <= DATA_W'(acc_sum >> len);
                        acc <= '0;
                        cnt <= '0;
                        len <= avg_log2;
                        cont <= en;
                    end
                end else tcnt <= tcnt + TW'(1);
                default: ;
            endcase
        end
    end
    sar_result_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(res),
        .dout(dout),
        .valid(dout_valid),
        .ready(dout_ready),
        .drop(drop)
    );
endmodule

// File: tb/tb_sar_conv_sequencer.sv
// tb_sar_conv_sequencer: directed vectors plus hand sequences against a behavioural SAR model
module tb_sar_conv_sequencer;
    logic clk, rst, en, start, cnvst, eoc, dout_valid, dout_ready, busy, timeout_err, overflow, err_clr;
    logic [15:0] period;
    logic [1:0] avg_log2;
    logic [9:0] sar_in, dout;
    int cyc = 0, checks = 0, failures = 0;
    int cdown = -1, eoc_n = 0, eoc_t = 0, lat = 24, n, s, r, base;
    bit sar_on = 1;
    logic [9:0] code_q[$];
    int cnv_q[$];
    typedef struct packed {
        logic [1:0] avg;
        logic [7:0][9:0] code;
        logic [9:0] exp;
    } vec_t;
    vec_t vt [6];
    logic [9:0] drain [4];

    sar_conv_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .period(period), .avg_log2(avg_log2),
        .cnvst(cnvst), .eoc(eoc), .sar_in(sar_in), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .timeout_err(timeout_err), .overflow(overflow),
        .err_clr(err_clr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // SAR model: eoc (with the next queued code) lat cycles after each cnvst cycle
    initial begin
        eoc = 0;
        sar_in = 0;
        forever begin
            @(negedge clk);
            eoc = 0;
            if (rst) cdown = -1;
            else begin
                if (cdown > 0) begin
                    cdown--;
                    if (cdown == 0) begin
                        eoc = 1;
                        sar_in = code_q.size() > 0 ? code_q.pop_front() : 10'd0;
                        eoc_n++;
                        eoc_t = cyc;
                        cdown = -1;
                    end
                end
                if (cnvst) begin
                    cnv_q.push_back(cyc);
                    if (sar_on) cdown = lat;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1;
        s = cyc;
        step();
        start = 0;
    endtask

    task automatic pop_one();
        dout_ready = 1;
        step();
        dout_ready = 0;
    endtask

    initial begin
        rst = 1; en = 0; start = 0; period = 0; avg_log2 = 0; dout_ready = 0; err_clr = 0;
        vt[0] = '{2'd2, {40'd0, 10'd104, 10'd102, 10'd101, 10'd100}, 10'd101};
        vt[1] = '{2'd1, {60'd0, 10'd1022, 10'd1023}, 10'd1022};
        vt[2] = '{2'd3, {8{10'd1023}}, 10'd1023};
        vt[3] = '{2'd1, {60'd0, 10'd4, 10'd3}, 10'd3};
        vt[4] = '{2'd2, {40'd0, 10'd3, 10'd0, 10'd0, 10'd0}, 10'd0};
        vt[5] = '{2'd2, {40'd0, 10'd5, 10'd3, 10'd2, 10'd1}, 10'd2};
        repeat (3) step();
        rst = 0;
        step();
        chk("rst_cnvst", cnvst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_overflow", overflow, 0);

        // single conversion: latency of cnvst and of dout_valid
        code_q.push_back(10'h2A5);
        cnv_q.delete();
        pulse_start();
        n = 0;
        while (!dout_valid && n < 100) begin step(); n++; end
        chk("t1_valid_wait", n < 100, 1);
        chk("t1_cnvst_latency", cnv_q.size() > 0 ? cnv_q[0] - s : -1, 1);
        chk("t1_cnvst_count", cnv_q.size(), 1);
        chk("t1_eoc_to_valid", cyc - eoc_t, 2);
        chk("t1_dout", dout, 10'h2A5);
        chk("t1_busy_low", busy, 0);
        pop_one();
        chk("t1_empty_after_pop", dout_valid, 0);

        // table of one-shot averaged bursts
        for (int i = 0; i < 6; i++) begin
            code_q.delete();
            cnv_q.delete();
            avg_log2 = vt[i].avg;
            for (int j = 0; j < (1 << vt[i].avg); j++) code_q.push_back(vt[i].code[j]);
            pulse_start();
            n = 0;
            while (!dout_valid && n < 400) begin step(); n++; end
            chk($sformatf("vec%0d_valid_wait", i), n < 400, 1);
            chk($sformatf("vec%0d_dout", i), dout, vt[i].exp);
            chk($sformatf("vec%0d_cnvst_count", i), cnv_q.size(), 1 << vt[i].avg);
            chk($sformatf("vec%0d_busy_low", i), busy, 0);
            pop_one();
            chk($sformatf("vec%0d_empty", i), dout_valid, 0);
        end

        // continuous mode spacing: period 40, then period shorter than conversion
        avg_log2 = 0;
        period = 40;
        dout_ready = 1;
        cnv_q.delete();
        en = 1;
        repeat (200) step();
        chk("t3_p40_count", cnv_q.size() >= 4, 1);
        for (int i = 1; i < cnv_q.size(); i++) chk($sformatf("t3_p40_gap%0d", i), cnv_q[i] - cnv_q[i-1], 40);
        period = 5;
        repeat (50) step();
        cnv_q.delete();
        repeat (130) step();
        chk("t3_p5_count", cnv_q.size() >= 4, 1);
        for (int i = 1; i < cnv_q.size(); i++) chk($sformatf("t3_p5_gap%0d", i), cnv_q[i] - cnv_q[i-1], 25);
        en = 0;
        n = 0;
        while (busy && n < 60) begin step(); n++; end
        chk("t3_idle_after_en_low", busy, 0);
        repeat (5) step();
        dout_ready = 0;
        chk("t3_drained", dout_valid, 0);

        // timeout: SAR never answers
        sar_on = 0;
        period = 0;
        cnv_q.delete();
        pulse_start();
        r = cnv_q.size() > 0 ? cnv_q[0] : cyc;
        while (cyc < r + 62) step();
        chk("t4_no_err_early", timeout_err, 0);
        chk("t4_busy_early", busy, 1);
        step();
        step();
        chk("t4_err_set", timeout_err, 1);
        chk("t4_idle", busy, 0);
        chk("t4_no_push", dout_valid, 0);
        chk("t4_single_cnvst", cnv_q.size(), 1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("t4_err_cleared", timeout_err, 0);
        sar_on = 1;

        // FIFO fill, drop on full, push+pop on full
        code_q.delete();
        for (int k = 1; k <= 6; k++) code_q.push_back(10'(k));
        base = eoc_n;
        en = 1;
        n = 0;
        while (eoc_n < base + 5 && n < 300) begin step(); n++; end
        chk("t5_fifth_eoc", eoc_n, base + 5);
        step();
        chk("t5_no_overflow_yet", overflow, 0);
        step();
        chk("t5_overflow", overflow, 1);
        chk("t5_full_valid", dout_valid, 1);
        chk("t5_head", dout, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("t5_overflow_cleared", overflow, 0);
        n = 0;
        while (eoc_n < base + 6 && n < 60) begin step(); n++; end
        chk("t5_sixth_eoc", eoc_n, base + 6);
        en = 0;
        step();
        dout_ready = 1;
        step();
        dout_ready = 0;
        chk("t5_pushpop_no_overflow", overflow, 0);
        drain = '{10'd2, 10'd3, 10'd4, 10'd6};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_drain%0d", k), dout, drain[k]);
            pop_one();
        end
        chk("t5_empty", dout_valid, 0);
        chk("t5_idle", busy, 0);

        // asynchronous reset mid-conversion
        code_q.delete();
        code_q.push_back(10'h155);
        pulse_start();
        n = 0;
        while (!dout_valid && n < 100) begin step(); n++; end
        pulse_start();
        repeat (10) step();
        chk("t6_busy_before", busy, 1);
        chk("t6_valid_before", dout_valid, 1);
        chk("t6_dout_before", dout, 10'h155);
        rst = 1;
        #1;
        chk("t6_busy_reset", busy, 0);
        chk("t6_cnvst_reset", cnvst, 0);
        chk("t6_valid_reset", dout_valid, 0);
        chk("t6_dout_reset", dout, 0);
        step();
        step();
        rst = 0;
        cnv_q.delete();
        repeat (40) step();
        chk("t6_no_cnvst_after_release", cnv_q.size(), 0);
        chk("t6_idle_after_release", busy, 0);
        pulse_start();
        chk("t6_cnvst_after_start", cnv_q.size() > 0 ? cnv_q[0] - s : -1, 1);
        n = 0;
        while (busy && n < 60) begin step(); n++; end
        chk("t6_done", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
